// File: rtl/fp_result_stage.sv
// fp_result_stage: registered output stage behind the combinational FP16 multiplier.
//
// Accepts a 16-bit FP16 result plus its {negative, zero, overflow, cout} flags over
// a valid/ready handshake. Each result is classified on entry and stored with it.
// A 2-entry skid buffer (main + skid register) decouples in_ready from out_ready.
// The stage also keeps sticky status bits and a saturating overflow-event counter.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   in_valid/in_ready       upstream handshake (in_ready is registered)
//   in_result, in_flags     multiplier result and flags
//   out_valid/out_ready     downstream handshake
//   out_result, out_flags   buffered result and flags
//   out_class               0=zero 1=subnormal 2=normal 3=inf 4=NaN
//   sticky_clear            clears sticky_status and ovf_count
//   sticky_status           {nan_seen, inf_seen, ovf_seen, zero_seen, neg_seen}
//   ovf_count               saturating count of accepted overflow-flagged results

module fp_result_stage #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_result,
   input  logic [3:0]       in_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_result,
   output logic [3:0]       out_flags,
   output logic [2:0]       out_class,
   input  logic             sticky_clear,
   output logic [4:0]       sticky_status,
   output logic [CNT_W-1:0] ovf_count
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e            state;
   logic [15:0]       skid_result;
   logic [3:0]        skid_flags;
   logic [2:0]        skid_class;

   logic              accept;
   logic              pop;
   logic [2:0]        in_class;
   logic [4:0]        sticky_next;
   logic [CNT_W-1:0]  cnt_base;
   logic [CNT_W-1:0]  cnt_next;

   function automatic logic [2:0] classify(input logic [15:0] r);
      logic [4:0] e;
      logic [9:0] m;
      e = r[14:10];
      m = r[9:0];
      if (e == 5'd0)       classify = (m == 10'd0) ? 3'd0 : 3'd1;
      else if (e == 5'd31) classify = (m == 10'd0) ? 3'd3 : 3'd4;
      else                 classify = 3'd2;
   endfunction

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   // Clear is applied before the accepted entry's contribution.
   always_comb begin
      in_class    = classify(in_result);
      sticky_next = sticky_clear ? 5'd0 : sticky_status;
      cnt_base    = sticky_clear ? '0 : ovf_count;
      cnt_next    = cnt_base;
      if (accept) begin
         sticky_next = sticky_next | {in_class == 3'd4, in_class == 3'd3,
                                      in_flags[1], in_flags[2], in_flags[3]};
         if (in_flags[1] && (cnt_base != CntMax)) begin
            cnt_next = cnt_base + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= StEmpty;
         in_ready      <= 1'b1;
         out_valid     <= 1'b0;
         out_result    <= '0;
         out_flags     <= '0;
         out_class     <= '0;
         skid_result   <= '0;
         skid_flags    <= '0;
         skid_class    <= '0;
         sticky_status <= '0;
         ovf_count     <= '0;
      end else begin
         sticky_status <= sticky_next;
         ovf_count     <= cnt_next;
         unique case (state)
            StEmpty: begin
               if (accept) begin
                  out_result <= in_result;
                  out_flags  <= in_flags;
                  out_class  <= in_class;
                  out_valid  <= 1'b1;
                  state      <= StOne;
               end
            end
            StOne: begin
               if (accept && pop) begin
                  out_result <= in_result;
                  out_flags  <= in_flags;
                  out_class  <= in_class;
               end else if (accept) begin
                  skid_result <= in_result;
                  skid_flags  <= in_flags;
                  skid_class  <= in_class;
                  in_ready    <= 1'b0;
                  state       <= StFull;
               end else if (pop) begin
                  out_valid <= 1'b0;
                  state     <= StEmpty;
               end
            end
            StFull: begin
               // in_ready is low here, so only a pop can happen.
               if (pop) begin
                  out_result <= skid_result;
                  out_flags  <= skid_flags;
                  out_class  <= skid_class;
                  in_ready   <= 1'b1;
                  state      <= StOne;
               end
            end
            default: begin
               state     <= StEmpty;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_result_stage.sv
// Self-checking bench for fp_result_stage: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based behavioural model.

module tb_fp_result_stage;

   localparam int unsigned CNT_W = 2;
   localparam int CntMaxI = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_result;
   logic [3:0]       in_flags;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_result;
   logic [3:0]       out_flags;
   logic [2:0]       out_class;
   logic             sticky_clear;
   logic [4:0]       sticky_status;
   logic [CNT_W-1:0] ovf_count;

   fp_result_stage #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_result     (in_result),
      .in_flags      (in_flags),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_flags     (out_flags),
      .out_class     (out_class),
      .sticky_clear  (sticky_clear),
      .sticky_status (sticky_status),
      .ovf_count     (ovf_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] r;
      logic [3:0]  f;
      logic [2:0]  c;
   } ent_t;

   ent_t     q[$];
   logic [4:0] m_sticky;
   int       m_cnt;
   int       checks = 0;
   int       errors = 0;
   bit       chk_en = 1'b0;

   function automatic logic [2:0] model_class(input logic [15:0] r);
      int e;
      int m;
      e = int'(r[14:10]);
      m = int'(r[9:0]);
      if (e == 0)  return (m == 0) ? 3'd0 : 3'd1;
      if (e == 31) return (m == 0) ? 3'd3 : 3'd4;
      return 3'd2;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a FIFO of at most two entries plus status.
   always @(posedge clk) begin
      bit   acc;
      bit   pp;
      ent_t e;
      if (!reset_n) begin
         q.delete();
         m_sticky = 5'd0;
         m_cnt    = 0;
      end else begin
         acc = in_valid && (q.size() < 2);
         pp  = (q.size() > 0) && out_ready;
         if (sticky_clear) begin
            m_sticky = 5'd0;
            m_cnt    = 0;
         end
         if (pp) void'(q.pop_front());
         if (acc) begin
            e.r = in_result;
            e.f = in_flags;
            e.c = model_class(in_result);
            q.push_back(e);
            if (in_flags[3]) m_sticky[0] = 1'b1;
            if (in_flags[2]) m_sticky[1] = 1'b1;
            if (in_flags[1]) m_sticky[2] = 1'b1;
            if (e.c == 3'd3) m_sticky[3] = 1'b1;
            if (e.c == 3'd4) m_sticky[4] = 1'b1;
            if (in_flags[1] && m_cnt < CntMaxI) m_cnt++;
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
         chk("sticky_status", 32'(sticky_status), 32'(m_sticky));
         chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
         if (q.size() != 0) begin
            chk("out_result", 32'(out_result), 32'(q[0].r));
            chk("out_flags", 32'(out_flags), 32'(q[0].f));
            chk("out_class", 32'(out_class), 32'(q[0].c));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] f);
      in_valid  = v;
      in_result = r;
      in_flags  = f;
   endtask

   initial begin
      logic [15:0] rr;
      reset_n      = 1'b0;
      in_valid     = 1'b1;  // must be ignored during reset
      in_result    = 16'h1234;
      in_flags     = 4'b1111;
      out_ready    = 1'b0;
      sticky_clear = 1'b0;
      tick();
      tick();
      chk_en  = 1'b1;
      reset_n = 1'b1;
      in_valid = 1'b0;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_result", 32'(out_result), 32'd0);
      chk("rst out_flags", 32'(out_flags), 32'd0);
      chk("rst out_class", 32'(out_class), 32'd0);
      chk("rst sticky", 32'(sticky_status), 32'd0);
      chk("rst ovf_count", 32'(ovf_count), 32'd0);

      // Single pass.
      out_ready = 1'b1;
      drive(1'b1, 16'h4000, 4'b0000);
      tick();
      drive(1'b0, 16'h0, 4'b0000);
      chk("pass out_valid", 32'(out_valid), 32'd1);
      chk("pass out_result", 32'(out_result), 32'h4000);
      chk("pass out_class", 32'(out_class), 32'd2);
      chk("pass sticky", 32'(sticky_status), 32'd0);
      tick();

      // Backpressure.
      out_ready = 1'b0;
      drive(1'b1, 16'h3C00, 4'b0000);
      tick();
      drive(1'b1, 16'hC400, 4'b1000);
      tick();
      drive(1'b0, 16'h0, 4'b0000);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp out_result hold", 32'(out_result), 32'h3C00);
      chk("bp neg_seen", 32'(sticky_status[0]), 32'd1);
      tick();
      chk("bp still held", 32'(out_result), 32'h3C00);
      out_ready = 1'b1;
      tick();
      chk("bp second out", 32'(out_result), 32'hC400);
      chk("bp in_ready back", 32'(in_ready), 32'd1);
      tick();
      chk("bp drained", 32'(out_valid), 32'd0);

      // Special values (start from clean status).
      sticky_clear = 1'b1;
      tick();
      sticky_clear = 1'b0;
      drive(1'b1, 16'h7C00, 4'b0010);
      tick();
      chk("sp class inf", 32'(out_class), 32'd3);
      drive(1'b1, 16'h7FFF, 4'b0010);
      tick();
      chk("sp class nan", 32'(out_class), 32'd4);
      drive(1'b1, 16'h0001, 4'b0000);
      tick();
      chk("sp class sub", 32'(out_class), 32'd1);
      drive(1'b0, 16'h0, 4'b0000);
      tick();
      chk("sp sticky", 32'(sticky_status), 32'b11100);
      chk("sp ovf_count", 32'(ovf_count), 32'd2);

      // Counter saturation.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 16'h7BFF, 4'b0010);
         tick();
      end
      drive(1'b0, 16'h0, 4'b0000);
      chk("sat ovf_count", 32'(ovf_count), 32'd3);
      tick();
      chk("sat ovf_count hold", 32'(ovf_count), 32'd3);
      sticky_clear = 1'b1;
      tick();
      sticky_clear = 1'b0;
      chk("clr ovf_count", 32'(ovf_count), 32'd0);
      chk("clr sticky", 32'(sticky_status), 32'd0);

      // Clear colliding with accept.
      drive(1'b1, 16'h7C00, 4'b0010);
      tick();
      drive(1'b1, 16'h8000, 4'b1100);
      sticky_clear = 1'b1;
      tick();
      sticky_clear = 1'b0;
      drive(1'b0, 16'h0, 4'b0000);
      chk("coll sticky", 32'(sticky_status), 32'b00011);
      chk("coll ovf_count", 32'(ovf_count), 32'd0);
      chk("coll class", 32'(out_class), 32'd0);
      tick();

      // Reset mid-operation from FULL.
      out_ready = 1'b0;
      drive(1'b1, 16'h1234, 4'b0010);
      tick();
      drive(1'b1, 16'h5678, 4'b1000);
      tick();
      chk("full in_ready", 32'(in_ready), 32'd0);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      drive(1'b0, 16'h0, 4'b0000);
      chk("mrst out_valid", 32'(out_valid), 32'd0);
      chk("mrst in_ready", 32'(in_ready), 32'd1);
      chk("mrst out_result", 32'(out_result), 32'd0);
      chk("mrst sticky", 32'(sticky_status), 32'd0);
      chk("mrst ovf_count", 32'(ovf_count), 32'd0);
      out_ready = 1'b1;
      drive(1'b1, 16'h3800, 4'b0000);
      tick();
      drive(1'b0, 16'h0, 4'b0000);
      chk("mrst first out", 32'(out_result), 32'h3800);
      tick();

      // Randomized traffic checked by the per-cycle compare process.
      for (int i = 0; i < 3000; i++) begin
         rr = 16'($urandom);
         case ($urandom_range(0, 5))
            0: rr[14:10] = 5'd0;
            1: rr[14:10] = 5'd31;
            2: rr[9:0]   = 10'd0;
            3: begin rr[14:10] = 5'd31; rr[9:0] = 10'd0; end
            default: ;
         endcase
         in_valid     = ($urandom_range(0, 3) != 0);
         in_result    = rr;
         in_flags     = 4'($urandom);
         out_ready    = ($urandom_range(0, 9) < 6);
         sticky_clear = ($urandom_range(0, 39) == 0);
         reset_n      = ($urandom_range(0, 199) != 0);
         tick();
      end
      reset_n      = 1'b1;
      in_valid     = 1'b0;
      sticky_clear = 1'b0;
      out_ready    = 1'b1;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
